// File: rtl/maple_pkg.sv
// Shared Maple bus definitions: receiver state encoding, pattern pulse counts and byte width.
package maple_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_END   = 2'd3
  } maple_state_e;

  localparam int MAPLE_START_PULSES = 4;
  localparam int MAPLE_END_PULSES   = 2;
  localparam int MAPLE_BYTE_W       = 8;

  localparam logic [8:0] MAPLE_BYTE_CNT_MAX = 9'd511;

endpackage

// File: rtl/maple_in_sync.sv
// Multi-bit input synchronizer (reset to idle-high) with one extra stage for rise/fall detection.
module maple_in_sync #(
  parameter int STAGES = 2,
  parameter int W      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0]             prev_q, prev_d;

  // Shift chain: index 0 takes the raw pins, the top index is the synced level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/maple_in.sv
// Maple bus receiver: start/end pattern detection and alternating-phase byte decode into a FIFO.
// Watchdog abort of stalled frames is compiled in only when MAPLE_IN_TIMEOUT_EN is defined.
module maple_in
  import maple_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pin1,
  input  logic                    pin5,
  input  logic                    enable,
  output logic [MAPLE_BYTE_W-1:0] fifo_data,
  output logic                    fifo_push,
  input  logic                    fifo_full,
  output logic                    frame_active,
  output logic                    start_seen,
  output logic                    end_seen,
  output logic                    err_framing,
  output logic                    err_overflow,
  output logic                    err_timeout,
  output logic [8:0]              byte_count
);

  localparam logic [2:0] START_CNT = 3'(MAPLE_START_PULSES);

  logic [1:0] lvl_s, rise_s, fall_s;
  logic       p1, p5, r1, f1, r5, f5, e1, e5, any_edge;

  maple_in_sync #(.STAGES(SYNC_STAGES), .W(2)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   ({pin5, pin1}),
    .level (lvl_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign p1 = lvl_s[0];
  assign p5 = lvl_s[1];
  assign r1 = rise_s[0];
  assign f1 = fall_s[0];
  assign r5 = rise_s[1];
  assign f5 = fall_s[1];
  assign e1 = r1 | f1;
  assign e5 = r5 | f5;
  assign any_edge = e1 | e5;

  maple_state_e            state_q, state_d;
  logic [2:0]              pcnt_q, pcnt_d, bcnt_q, bcnt_d;
  logic                    phase_q, phase_d, end_fall_q, end_fall_d;
  logic [MAPLE_BYTE_W-1:0] shreg_q, shreg_d, fifo_data_q, fifo_data_d, new_byte;
  logic [8:0]              byte_count_q, byte_count_d;
  logic                    push_q, push_d, frame_q, frame_d, start_q, start_d, end_q, end_d;
  logic                    ferr_q, ferr_d, ovf_q, ovf_d, tmo_err_q, tmo_err_d;
  logic                    got_bit, bit_val;

`ifdef MAPLE_IN_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]            tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state decode. Phase A: p1 clocks data on p5; phase B: p5 clocks data on p1.
  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    bcnt_d       = bcnt_q;
    phase_d      = phase_q;
    end_fall_d   = end_fall_q;
    shreg_d      = shreg_q;
    byte_count_d = byte_count_q;
    fifo_data_d  = fifo_data_q;
    push_d       = 1'b0;
    start_d      = 1'b0;
    end_d        = 1'b0;
    ferr_d       = 1'b0;
    ovf_d        = 1'b0;
    tmo_err_d    = 1'b0;
    got_bit      = 1'b0;
    bit_val      = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (f1 && p5) begin
            state_d = ST_START;
            pcnt_d  = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (e1 && e5) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
          end else if (r1) begin
            if (pcnt_q == START_CNT) begin
              state_d      = ST_DATA;
              start_d      = 1'b1;
              byte_count_d = 9'd0;
              bcnt_d       = 3'd0;
              phase_d      = 1'b0;
            end else begin
              state_d = ST_IDLE;
              ferr_d  = 1'b1;
            end
          end else if (f5) begin
            if (pcnt_q == START_CNT) begin
              state_d = ST_IDLE;
              ferr_d  = 1'b1;
            end else begin
              pcnt_d = pcnt_q + 3'd1;
            end
          end else begin
            pcnt_d = pcnt_q;
          end
        end
        ST_DATA: begin
          if (e1 && e5) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
          end else if (!phase_q) begin
            if (f1) begin
              got_bit = 1'b1;
              bit_val = p5;
              phase_d = 1'b1;
            end else if (e5 && !p1) begin
              state_d = ST_IDLE;
              ferr_d  = 1'b1;
            end else begin
              phase_d = phase_q;
            end
          end else begin
            if (f5) begin
              got_bit = 1'b1;
              bit_val = p1;
              phase_d = 1'b0;
            end else if (r1 && !p5 && bcnt_q == 3'd1) begin
              state_d    = ST_END;
              end_fall_d = 1'b0;
            end else if (e1 && !p5) begin
              state_d = ST_IDLE;
              ferr_d  = 1'b1;
            end else begin
              phase_d = phase_q;
            end
          end
        end
        ST_END: begin
          if (f1 && !e5 && !end_fall_q) begin
            end_fall_d = 1'b1;
          end else if (r5 && !e1 && end_fall_q) begin
            state_d = ST_IDLE;
            end_d   = 1'b1;
          end else if (any_edge) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
          end else begin
            end_fall_d = end_fall_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    new_byte = {shreg_q[MAPLE_BYTE_W-2:0], bit_val};
    if (got_bit) begin
      shreg_d = new_byte;
      if (bcnt_q == 3'd7) begin
        bcnt_d = 3'd0;
        if (!fifo_full) begin
          push_d       = 1'b1;
          fifo_data_d  = new_byte;
          byte_count_d = (byte_count_q == MAPLE_BYTE_CNT_MAX) ? byte_count_q : byte_count_q + 9'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        bcnt_d = bcnt_q + 3'd1;
      end
    end else begin
      shreg_d = shreg_q;
    end

`ifdef MAPLE_IN_TIMEOUT_EN
    tmo_cnt_d = (state_q == ST_IDLE || any_edge) ? '0 : tmo_cnt_q + TMO_W'(1);
    if (enable && state_q != ST_IDLE && !any_edge && tmo_cnt_q == TMO_LAST) begin
      state_d   = ST_IDLE;
      tmo_err_d = 1'b1;
    end else begin
      tmo_err_d = 1'b0;
    end
`endif

    frame_d = (state_d == ST_DATA) || (state_d == ST_END);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pcnt_q       <= 3'd0;
      bcnt_q       <= 3'd0;
      phase_q      <= 1'b0;
      end_fall_q   <= 1'b0;
      shreg_q      <= '0;
      byte_count_q <= 9'd0;
      fifo_data_q  <= '0;
      push_q       <= 1'b0;
      frame_q      <= 1'b0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      ferr_q       <= 1'b0;
      ovf_q        <= 1'b0;
      tmo_err_q    <= 1'b0;
`ifdef MAPLE_IN_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      bcnt_q       <= bcnt_d;
      phase_q      <= phase_d;
      end_fall_q   <= end_fall_d;
      shreg_q      <= shreg_d;
      byte_count_q <= byte_count_d;
      fifo_data_q  <= fifo_data_d;
      push_q       <= push_d;
      frame_q      <= frame_d;
      start_q      <= start_d;
      end_q        <= end_d;
      ferr_q       <= ferr_d;
      ovf_q        <= ovf_d;
      tmo_err_q    <= tmo_err_d;
`ifdef MAPLE_IN_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign fifo_data    = fifo_data_q;
  assign fifo_push    = push_q;
  assign frame_active = frame_q;
  assign start_seen   = start_q;
  assign end_seen     = end_q;
  assign err_framing  = ferr_q;
  assign err_overflow = ovf_q;
  assign err_timeout  = tmo_err_q;
  assign byte_count   = byte_count_q;

endmodule
